c17_bist_ctrl: RTL and testbench

Self-test controller that sits directly upstream and downstream of the c17 combinational core. It drives the five c17 primary inputs with a maximal-length LFSR pattern sequence, compacts the two c17 outputs into a MISR, and reports a final signature plus pass/fail against a golden value. It replaces file-driven pattern application with an on-chip, cycle-accurate pattern source and response compactor.

---
 rtl/bist_pkg.sv | 24 ++
 rtl/bist_misr.sv | 28 ++
 rtl/c17_bist_ctrl.sv | 81 ++++++++
 tb/tb_c17_bist_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the c17 BIST controller: FSM states,
// LFSR/MISR widths and feedback polynomials.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  localparam int LFSR_W = 5;
  localparam int MISR_W = 8;
  localparam int CNT_W  = 5;

  // x^5+x^3+1 as a Fibonacci tap mask (bits 4 and 2 feed back).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
  // x^8+x^4+x^3+x^2+1 with the x^8 term implied.
  localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// 8-bit Galois MISR with synchronous clear and enable, compacting the
// 2-bit c17 response into bits 1:0 every enabled cycle.
module bist_misr
  import bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [1:0]        d,
  output logic [MISR_W-1:0] sig
);

  logic fb;
  assign fb = sig[MISR_W-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      // Unknowns on d are deliberately allowed to poison the signature.
      sig <= {sig[MISR_W-2:0], 1'b0}
           ^ (fb ? MISR_POLY : '0)
           ^ {{(MISR_W-2){1'b0}}, d};
    end
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the c17 core: LFSR pattern source, pattern counter
// and IDLE/RUN/DONE sequencing around a response-compacting MISR.
module c17_bist_ctrl
  import bist_pkg::*;
#(
  parameter int                N_PATTERNS = 31,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 5'b00001,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [LFSR_W-1:0] pi,
  input  logic [1:0]        po,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pat_cnt,
  output logic [MISR_W-1:0] signature,
  output logic              pass,
  output bist_state_e       fsm_state
);

  bist_state_e       state;
  logic [LFSR_W-1:0] lfsr;
  logic              accept;
  logic              last;

  // start is only honoured outside RUN; it also clears the MISR.
  assign accept = start && (state != RUN);
  assign last   = (pat_cnt == CNT_W'(N_PATTERNS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      pat_cnt <= '0;
      pi      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            lfsr    <= LFSR_SEED;
            pi      <= LFSR_SEED;
            pat_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          lfsr <= lfsr_next(lfsr);
          if (last) begin
            state <= DONE;
            pi    <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pat_cnt <= pat_cnt + CNT_W'(1);
            pi      <= lfsr_next(lfsr);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bist_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == RUN),
    .d   (po),
    .sig (signature)
  );

  assign pass      = done && (signature == GOLDEN_SIG);
  assign fsm_state = state;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl: reference c17/LFSR/MISR model,
// expected-pattern and expected-signature queues popped as the DUT runs.
module tb_c17_bist_ctrl;
  import bist_pkg::*;

  localparam int          NPAT = 31;
  localparam logic [4:0]  SEED = 5'b00001;

  // ---------------- reference model ----------------
  function automatic logic [1:0] c17_model(input logic [4:0] p, input bit n22_sa0);
    logic n10, n11, n16, n19, n22, n23;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    n22 = ~(n10 & n16);
    n23 = ~(n16 & n19);
    if (n22_sa0) n22 = 1'b0;
    return {n23, n22};
  endfunction

  function automatic logic [4:0] lfsr_model(input logic [4:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction

  function automatic logic [7:0] misr_model(input logic [7:0] m, input logic [1:0] d);
    logic [7:0] n;
    logic fb;
    fb   = m[7];
    n[0] = fb ^ d[0];
    n[1] = m[0] ^ d[1];
    n[2] = m[1] ^ fb;
    n[3] = m[2] ^ fb;
    n[4] = m[3] ^ fb;
    n[5] = m[4];
    n[6] = m[5];
    n[7] = m[6];
    return n;
  endfunction

  function automatic logic [1:0] resp_model(input logic [4:0] p, input int mode);
    if (mode == 1) return 2'b00;
    return c17_model(p, mode == 2);
  endfunction

  function automatic logic [7:0] calc_sig(input int mode);
    logic [4:0] l;
    logic [7:0] s;
    l = SEED;
    s = 8'h00;
    for (int k = 0; k < NPAT; k++) begin
      s = misr_model(s, resp_model(l, mode));
      l = lfsr_model(l);
    end
    return s;
  endfunction

  localparam logic [7:0] GOLD = calc_sig(0);

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [4:0] pi, pi1;
  logic [1:0] po, po1;
  logic       busy, done, pass, busy1, done1, pass1;
  logic [4:0] pat_cnt, pat_cnt1;
  logic [7:0] signature, signature1;
  bist_state_e fsm_state, fsm_state1;
  int         po_mode;

  always #5 clk = ~clk;

  always_comb begin
    po = resp_model(pi, po_mode);
  end

  c17_bist_ctrl #(.N_PATTERNS(NPAT), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .pi(pi), .po(po), .busy(busy),
    .done(done), .pat_cnt(pat_cnt), .signature(signature), .pass(pass),
    .fsm_state(fsm_state)
  );

  c17_bist_ctrl #(.N_PATTERNS(1), .LFSR_SEED(SEED), .GOLDEN_SIG(8'h01)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pi(pi1), .po(po1), .busy(busy1),
    .done(done1), .pat_cnt(pat_cnt1), .signature(signature1), .pass(pass1),
    .fsm_state(fsm_state1)
  );

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];
  logic [7:0] sig_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pi"}, pi, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pat_cnt"}, pat_cnt, 0);
    check({tag, "_sig"}, signature, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_state"}, fsm_state, IDLE);
  endtask

  // Full run on the main DUT. abort_at >= 0 pulses rst during that pattern.
  task automatic run_main(input int mode, input bit hold, input int abort_at);
    logic [4:0]  l;
    logic [7:0]  s;
    logic [4:0]  e;
    logic [7:0]  es;
    logic [31:0] seen;
    logic [4:0]  first6 [6];
    int          uniq;
    first6 = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
    po_mode = mode;
    l = SEED;
    s = 8'h00;
    for (int k = 0; k < NPAT; k++) begin
      exp_q.push_back(l);
      s = misr_model(s, resp_model(l, mode));
      l = lfsr_model(l);
    end
    sig_q.push_back(s);
    seen = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = hold;
    for (int k = 0; k < NPAT; k++) begin
      @(negedge clk);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_pat_cnt", pat_cnt, k);
      e = exp_q.pop_front();
      check("run_pi", pi, e);
      if (k < 6) check("run_pi_first6", pi, first6[k]);
      seen[pi] = 1'b1;
      if (k == NPAT - 1) start = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        exp_q.delete();
        sig_q.delete();
        return;
      end
    end
    uniq = $countones(seen);
    check("lfsr_unique", uniq, NPAT);
    check("lfsr_no_zero", seen[0], 0);
    @(negedge clk);
    es = sig_q.pop_front();
    check("done_flag", done, 1);
    check("done_busy", busy, 0);
    check("done_pi", pi, 0);
    check("done_state", fsm_state, DONE);
    check("done_sig", signature, es);
    check("done_pass", pass, (es == GOLD));
    @(negedge clk);
    check("done_hold_sig", signature, es);
    check("done_hold_flag", done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; po1 = 2'b00; po_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_outputs("idle");
    end

    // Golden run with real c17 core.
    run_main(0, 1'b0, -1);
    // po forced to 00: signature must be zero.
    run_main(1, 1'b0, -1);
    check("zero_sig_const", calc_sig(1), 8'h00);
    // N22 stuck-at-0: must not pass.
    run_main(2, 1'b0, -1);
    check("stuck_pass_low", pass, 0);
    // Reset mid-run, then uninterrupted run reproduces the golden signature.
    run_main(0, 1'b0, 10);
    run_main(0, 1'b0, -1);
    check("after_abort_sig", signature, GOLD);
    // start held high through RUN, then restart directly from DONE.
    run_main(0, 1'b1, -1);
    run_main(0, 1'b0, -1);
    check("restart_sig", signature, GOLD);
    check("restart_pass", pass, 1);

    // Single-pattern instance: po=01 on the first pattern only.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; po1 = 2'b01;
    @(negedge clk);
    check("n1_busy", busy1, 1);
    check("n1_pi", pi1, SEED);
    check("n1_done_early", done1, 0);
    @(posedge clk); #1 po1 = 2'b00;
    @(negedge clk);
    check("n1_done", done1, 1);
    check("n1_busy_low", busy1, 0);
    check("n1_sig", signature1, 8'h01);
    check("n1_pass", pass1, 1);
    @(negedge clk);
    check("n1_sig_hold", signature1, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
